// File: rtl/fir_xifu_pkg.sv
// Shared types and constants for the FIR XIFU execute/memory stage.
package fir_xifu_pkg;

    localparam int unsigned FIR_XIFU_XLEN = 32;
    localparam int unsigned FIR_XIFU_ID_W = 4;
    localparam int unsigned FIR_XIFU_RF_W = 5;

    localparam logic [3:0] FIR_XIFU_BE_WORD = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CMT,
        REQ,
        RESP,
        DONE
    } fir_xifu_ex_state_e;

    typedef struct packed {
        logic                     valid;
        logic                     we;
        logic [FIR_XIFU_RF_W-1:0] rd;
        logic [FIR_XIFU_XLEN-1:0] data;
        logic [FIR_XIFU_ID_W-1:0] id;
        logic                     err;
    } fir_xifu_ex2wb_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fir_xifu_ex.sv
// FIR XIFU execute/memory stage: one decoded load/store in flight, issued to the
// XIF memory interface only after commit, result forwarded to writeback.
module fir_xifu_ex
    import fir_xifu_pkg::*;
#(
    parameter int unsigned XLEN = FIR_XIFU_XLEN,
    parameter int unsigned ID_W = FIR_XIFU_ID_W,
    parameter int unsigned RF_W = FIR_XIFU_RF_W
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [XLEN-1:0] id_base_i,
    input  logic [11:0]     id_offset_i,
    input  logic            id_store_i,
    input  logic [RF_W-1:0] id_rd_i,
    input  logic [ID_W-1:0] id_id_i,
    input  logic [XLEN-1:0] st_data_i,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [ID_W-1:0] mem_id_o,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [RF_W-1:0] wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [ID_W-1:0] wb_id_o,
    output logic            wb_err_o
);

    fir_xifu_ex_state_e state_q;
    logic [XLEN-1:0]    addr_q;
    logic               store_q;
    logic [RF_W-1:0]    rd_q;
    logic [ID_W-1:0]    id_q;
    logic [XLEN-1:0]    wdata_q;
    fir_xifu_ex2wb_t    wb_q;

    logic [XLEN-1:0] addr_in;
    logic            cmt_hit_in;
    logic            cmt_hit_q;

    assign addr_in    = id_base_i + {{(XLEN-12){id_offset_i[11]}}, id_offset_i};
    assign cmt_hit_in = commit_valid_i && (commit_id_i == id_id_i);
    assign cmt_hit_q  = commit_valid_i && (commit_id_i == id_q);

    // A commit may arrive together with the op, so IDLE resolves it against the incoming id.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            store_q <= 1'b0;
            rd_q    <= '0;
            id_q    <= '0;
            wdata_q <= '0;
            wb_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (id_valid_i) begin
                        addr_q  <= addr_in;
                        store_q <= id_store_i;
                        rd_q    <= id_rd_i;
                        id_q    <= id_id_i;
                        wdata_q <= st_data_i;
                        if (!cmt_hit_in) begin
                            state_q <= WAIT_CMT;
                        end else if (commit_kill_i) begin
                            state_q <= IDLE;
                        end else if (is_misaligned(addr_in[1:0])) begin
                            wb_q.valid <= 1'b1;
                            wb_q.we    <= 1'b0;
                            wb_q.rd    <= id_rd_i;
                            wb_q.data  <= '0;
                            wb_q.id    <= id_id_i;
                            wb_q.err   <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                WAIT_CMT: begin
                    if (cmt_hit_q) begin
                        if (commit_kill_i) begin
                            state_q <= IDLE;
                        end else if (is_misaligned(addr_q[1:0])) begin
                            wb_q.valid <= 1'b1;
                            wb_q.we    <= 1'b0;
                            wb_q.rd    <= rd_q;
                            wb_q.data  <= '0;
                            wb_q.id    <= id_q;
                            wb_q.err   <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready_i) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid_i) begin
                        wb_q.valid <= 1'b1;
                        wb_q.we    <= !store_q && !mem_err_i;
                        wb_q.rd    <= rd_q;
                        wb_q.data  <= store_q ? '0 : mem_rdata_i;
                        wb_q.id    <= id_q;
                        wb_q.err   <= mem_err_i;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    wb_q.valid <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign id_ready_o  = (state_q == IDLE);
    assign mem_valid_o = (state_q == REQ);
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = store_q;
    assign mem_be_o    = FIR_XIFU_BE_WORD;
    assign mem_wdata_o = wdata_q;
    assign mem_id_o    = id_q;

    assign wb_valid_o = wb_q.valid;
    assign wb_we_o    = wb_q.valid && wb_q.we;
    assign wb_rd_o    = wb_q.rd;
    assign wb_data_o  = wb_q.data;
    assign wb_id_o    = wb_q.id;
    assign wb_err_o   = wb_q.valid && wb_q.err;

`ifndef SYNTHESIS
    // A memory result with no outstanding request would be silently dropped.
    rvalid_only_in_resp: assert property (
        @(posedge clk_i) disable iff (!rst_ni) mem_rvalid_i |-> (state_q == RESP)
    );
`endif

endmodule

// File: tb/tb_fir_xifu_ex.sv
// Scoreboard bench for fir_xifu_ex: expected writebacks queued at issue, checked on strobe.
module tb_fir_xifu_ex;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        id_valid_i = 1'b0;
    logic        id_ready_o;
    logic [31:0] id_base_i = '0;
    logic [11:0] id_offset_i = '0;
    logic        id_store_i = 1'b0;
    logic [4:0]  id_rd_i = '0;
    logic [3:0]  id_id_i = '0;
    logic [31:0] st_data_i = '0;
    logic        commit_valid_i = 1'b0;
    logic [3:0]  commit_id_i = '0;
    logic        commit_kill_i = 1'b0;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_id_o;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_id_o;
    logic        wb_err_o;

    fir_xifu_ex dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_base_i(id_base_i), .id_offset_i(id_offset_i), .id_store_i(id_store_i),
        .id_rd_i(id_rd_i), .id_id_i(id_id_i), .st_data_i(st_data_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_id_o(mem_id_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .wb_id_o(wb_id_o), .wb_err_o(wb_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  id;
        logic        err;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   wb_cyc = 0;
    int   wb_count = 0;
    int   mem_count = 0;
    logic mem_prev = 1'b0;

    always @(posedge clk_i) cyc++;

    // Counts writeback strobes and request starts so silent events can be detected.
    always @(negedge clk_i) begin
        if (wb_valid_o) wb_count++;
        if (mem_valid_o && !mem_prev) mem_count++;
        mem_prev = mem_valid_o;
    end

    task automatic push_exp(input logic we, input logic [4:0] rd, input logic [31:0] data,
                            input logic [3:0] id, input logic err, input bit chk_data);
        exp_t e;
        e.we = we; e.rd = rd; e.data = data; e.id = id; e.err = err; e.chk_data = chk_data;
        exp_q.push_back(e);
    endtask

    task automatic drive_op(input logic [31:0] base, input logic [11:0] off, input logic store,
                            input logic [4:0] rd, input logic [3:0] id, input logic [31:0] sd,
                            input bit cmt_now);
        total++;
        if (id_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL accept_ready id=%0d: id_ready_o=%b expected 1", id, id_ready_o);
        end
        id_valid_i = 1'b1; id_base_i = base; id_offset_i = off; id_store_i = store;
        id_rd_i = rd; id_id_i = id; st_data_i = sd;
        commit_valid_i = cmt_now; commit_id_i = id; commit_kill_i = 1'b0;
        acc_cyc = cyc;
        @(negedge clk_i);
        id_valid_i = 1'b0; commit_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
        @(negedge clk_i);
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    endtask

    task automatic serve_mem(input logic [31:0] rdata, input logic err, input int stall,
                             input logic [31:0] exp_addr, input logic exp_we,
                             input logic [31:0] exp_wdata, input string name);
        for (int i = 0; i < 20 && !mem_valid_o; i++) @(negedge clk_i);
        total++;
        if (mem_valid_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s req_timeout: mem_valid_o=%b expected 1", name, mem_valid_o);
            return;
        end
        total++;
        if (mem_addr_o !== exp_addr || mem_we_o !== exp_we || mem_be_o !== 4'hF) begin
            bad++;
            $display("[TB] FAIL %s req_fields: addr=%h we=%b be=%h expected addr=%h we=%b be=f",
                     name, mem_addr_o, mem_we_o, mem_be_o, exp_addr, exp_we);
        end
        if (exp_we) begin
            total++;
            if (mem_wdata_o !== exp_wdata) begin
                bad++;
                $display("[TB] FAIL %s wdata: got %h expected %h", name, mem_wdata_o, exp_wdata);
            end
        end
        for (int s = 0; s < stall; s++) begin
            mem_ready_i = 1'b0;
            @(negedge clk_i);
            total++;
            if (mem_valid_o !== 1'b1 || mem_addr_o !== exp_addr ||
                (exp_we && mem_wdata_o !== exp_wdata)) begin
                bad++;
                $display("[TB] FAIL %s stall_stable: valid=%b addr=%h wdata=%h expected 1 %h %h",
                         name, mem_valid_o, mem_addr_o, mem_wdata_o, exp_addr, exp_wdata);
            end
        end
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    endtask

    task automatic wait_wb(input string name);
        exp_t e;
        for (int i = 0; i < 30 && !wb_valid_o; i++) @(negedge clk_i);
        total++;
        if (wb_valid_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s wb_timeout: wb_valid_o=%b expected 1", name, wb_valid_o);
            return;
        end
        wb_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s wb_unexpected: queue size 0 expected >0", name);
            return;
        end
        e = exp_q.pop_front();
        if (wb_we_o !== e.we || wb_rd_o !== e.rd || wb_id_o !== e.id || wb_err_o !== e.err) begin
            bad++;
            $display("[TB] FAIL %s wb_fields: we=%b rd=%0d id=%0d err=%b expected we=%b rd=%0d id=%0d err=%b",
                     name, wb_we_o, wb_rd_o, wb_id_o, wb_err_o, e.we, e.rd, e.id, e.err);
        end
        if (e.chk_data) begin
            total++;
            if (wb_data_o !== e.data) begin
                bad++;
                $display("[TB] FAIL %s wb_data: got %h expected %h", name, wb_data_o, e.data);
            end
        end
        @(negedge clk_i);
        total++;
        if (wb_valid_o !== 1'b0 || id_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s wb_one_cycle: wb_valid_o=%b id_ready_o=%b expected 0 1",
                     name, wb_valid_o, id_ready_o);
        end
    endtask

    task automatic check_latency(input int expected, input string name);
        total++;
        if (wb_cyc - acc_cyc !== expected) begin
            bad++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, wb_cyc - acc_cyc, expected);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        total++;
        if (id_ready_o !== 1'b1 || mem_valid_o !== 1'b0 || wb_valid_o !== 1'b0 ||
            mem_be_o !== 4'hF || mem_addr_o !== 32'h0 || wb_we_o !== 1'b0 || wb_err_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: ready=%b mvalid=%b wbv=%b be=%h addr=%h we=%b err=%b expected 1 0 0 f 0 0 0",
                     id_ready_o, mem_valid_o, wb_valid_o, mem_be_o, mem_addr_o, wb_we_o, wb_err_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_load();
        drive_op(32'h1000, 12'h010, 1'b0, 5'd5, 4'd3, 32'h0, 1'b0);
        push_exp(1'b1, 5'd5, 32'hCAFE0001, 4'd3, 1'b0, 1'b1);
        do_commit(4'd3, 1'b0);
        serve_mem(32'hCAFE0001, 1'b0, 0, 32'h1010, 1'b0, 32'h0, "load");
        wait_wb("load");
        check_latency(4, "load");
    endtask

    task automatic test_store_stall();
        drive_op(32'h2000, 12'hFFC, 1'b1, 5'd2, 4'd7, 32'h12345678, 1'b0);
        push_exp(1'b0, 5'd2, 32'h0, 4'd7, 1'b0, 1'b0);
        do_commit(4'd7, 1'b0);
        serve_mem(32'h0, 1'b0, 3, 32'h1FFC, 1'b1, 32'h12345678, "store");
        wait_wb("store");
        check_latency(7, "store");
    endtask

    task automatic test_kill();
        int wb0;
        int mem0;
        wb0 = wb_count; mem0 = mem_count;
        drive_op(32'h3000, 12'h000, 1'b0, 5'd1, 4'd9, 32'h0, 1'b0);
        do_commit(4'd4, 1'b0);
        do_commit(4'd9, 1'b1);
        repeat (6) @(negedge clk_i);
        total++;
        if (mem_count !== mem0 || wb_count !== wb0 || id_ready_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL kill: mem_reqs=%0d wb_strobes=%0d ready=%b expected %0d %0d 1",
                     mem_count, wb_count, id_ready_o, mem0, wb0);
        end
    endtask

    task automatic test_misaligned();
        int mem0;
        mem0 = mem_count;
        drive_op(32'h1002, 12'h000, 1'b0, 5'd3, 4'hA, 32'h0, 1'b0);
        push_exp(1'b0, 5'd3, 32'h0, 4'hA, 1'b1, 1'b0);
        do_commit(4'hA, 1'b0);
        wait_wb("misaligned");
        total++;
        if (mem_count !== mem0) begin
            bad++;
            $display("[TB] FAIL misaligned_noreq: mem_reqs=%0d expected %0d", mem_count, mem0);
        end
    endtask

    task automatic test_back_to_back();
        drive_op(32'h0000_0100, 12'h800, 1'b0, 5'd8, 4'd1, 32'h0, 1'b1);
        push_exp(1'b1, 5'd8, 32'h5A5A0F0F, 4'd1, 1'b0, 1'b1);
        serve_mem(32'h5A5A0F0F, 1'b0, 0, 32'hFFFF_F900, 1'b0, 32'h0, "b2b_first");
        wait_wb("b2b_first");
        check_latency(3, "b2b_first");
        drive_op(32'h0000_0040, 12'h7FC, 1'b1, 5'd9, 4'd2, 32'hA5A5_0001, 1'b1);
        push_exp(1'b0, 5'd9, 32'h0, 4'd2, 1'b0, 1'b0);
        serve_mem(32'h0, 1'b0, 1, 32'h0000_083C, 1'b1, 32'hA5A5_0001, "b2b_second");
        wait_wb("b2b_second");
    endtask

    task automatic test_reset_mid();
        int wb0;
        drive_op(32'h4000, 12'h004, 1'b0, 5'd6, 4'hC, 32'h0, 1'b1);
        for (int i = 0; i < 10 && !mem_valid_o; i++) @(negedge clk_i);
        total++;
        if (mem_valid_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_mid_req: mem_valid_o=%b expected 1", mem_valid_o);
        end
        wb0 = wb_count;
        rst_ni = 1'b0;
        #1;
        total++;
        if (mem_valid_o !== 1'b0 || id_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_abort: mvalid=%b ready=%b wbv=%b expected 0 1 0",
                     mem_valid_o, id_ready_o, wb_valid_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        total++;
        if (wb_count !== wb0 || mem_valid_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_quiet: wb_strobes=%0d mvalid=%b expected %0d 0",
                     wb_count, mem_valid_o, wb0);
        end
    endtask

    task automatic test_bus_error();
        drive_op(32'hFFFF_FFF0, 12'h020, 1'b0, 5'd4, 4'hB, 32'h0, 1'b0);
        push_exp(1'b0, 5'd4, 32'h0, 4'hB, 1'b1, 1'b0);
        do_commit(4'hB, 1'b0);
        serve_mem(32'hDEAD_BEEF, 1'b1, 1, 32'h0000_0010, 1'b0, 32'h0, "bus_err");
        wait_wb("bus_err");
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_stall();
        test_kill();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        test_bus_error();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running expected done");
        $fatal(1, "[TB] timeout");
    end

endmodule
